esprockell_uart_out: RTL and testbench

ESPROCKELL_UART_OUT -- requirements
Module: esprockell_uart_out

---
 rtl/esprockell_uart_out_if.sv | 8 +
 rtl/esprockell_uart_out.sv | 160 ++++++++++++++++
 tb/tb_esprockell_uart_out.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/esprockell_uart_out_if.sv
// Processor output port: one 16-bit word is offered in each cycle that oen_i is high.
interface esprockell_uart_out_if;
  logic               oen_i;
  logic signed [15:0] oval_i;

  modport master (output oen_i, output oval_i);
  modport slave  (input  oen_i, input  oval_i);
endinterface

// File: rtl/esprockell_uart_out.sv
// Buffers processor output words in a small FIFO and sends each word as two 8N1
// UART frames, high byte first, with a fixed integer number of clocks per bit.
module esprockell_uart_out #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 system1000,
  input  logic                 system1000_rst,
  esprockell_uart_out_if.slave out_if,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 full_o,
  output logic                 ovf_o
);
  localparam int DATA_W = 16;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, full;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              hi_q, hi_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              tx_q, tx_d;
  logic [7:0]        byte_sel;

  // A full FIFO still accepts a word when the transmitter pops in the same cycle.
  assign full = (count_q == DEPTH_C);
  assign pop  = (state_q == S_IDLE) && (count_q != '0);
  assign push = out_if.oen_i && !system1000_rst && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (out_if.oen_i & full & ~pop);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge system1000) begin
    if (push) mem_q[wr_ptr_q] <= out_if.oval_i;
  end

  // Transmitter state register
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      hi_q    <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      hi_q    <= hi_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge system1000) begin
    word_q <= word_d;
  end

  // Transmitter next-state logic; the baud counter runs CLKS_PER_BIT-1 down to 0 per bit.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    hi_d    = hi_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_START;
          word_d  = mem_q[rd_ptr_q];
          hi_d    = 1'b1;
          baud_d  = BAUD_LAST;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_LAST;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LAST;
          if (hi_q) begin
            hi_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is computed from the upcoming state so tx_o can come straight from a flop.
  always_comb begin
    byte_sel = hi_d ? word_d[15:8] : word_d[7:0];
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_sel[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (count_q != '0) || (state_q != S_IDLE);
  assign full_o = full;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_esprockell_uart_out.sv
// Randomised and directed bench for esprockell_uart_out against a word-level line model.
module tb_esprockell_uart_out;
  localparam int C        = 4;
  localparam int D        = 4;
  localparam int FRAME    = 10 * C;
  localparam int WORD_CYC = 20 * C;

  logic clk = 1'b0;
  logic rst;
  logic tx, busy, full, ovf;

  esprockell_uart_out_if bus ();

  esprockell_uart_out #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .out_if         (bus.slave),
    .tx_o           (tx),
    .busy_o         (busy),
    .full_o         (full),
    .ovf_o          (ovf)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: queue of buffered words, plus the word on the line and how far into it we are.
  logic [15:0] mq[$];
  int          rem  = 0;
  int          pos  = 0;
  logic [15:0] cur  = '0;
  logic        movf = 1'b0;

  bit          cap[$];
  logic [7:0]  dec_bytes[$];
  int          dec_starts[$];

  function automatic logic exp_tx();
    int f, b;
    logic [7:0] byt;
    if (rem == 0) return 1'b1;
    f   = pos / FRAME;
    b   = (pos % FRAME) / C;
    byt = (f == 0) ? cur[15:8] : cur[7:0];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return byt[b-1];
  endfunction

  function automatic logic [3:0] exp_vec();
    return {exp_tx(), (mq.size() > 0) || (rem > 0), mq.size() == D, movf};
  endfunction

  function automatic logic [3:0] act_vec();
    return {tx, busy, full, ovf};
  endfunction

  task automatic step(input logic en, input logic [15:0] v, input logic r);
    bit pop_m, was_full;
    bus.oen_i  = en;
    bus.oval_i = v;
    rst        = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      rem  = 0;
      pos  = 0;
      movf = 1'b0;
    end else begin
      pop_m    = (rem == 0) && (mq.size() > 0);
      was_full = (mq.size() == D);
      if (rem > 0) begin
        rem--;
        pos++;
      end
      if (pop_m) begin
        cur = mq.pop_front();
        rem = WORD_CYC;
        pos = 0;
      end
      if (en && (!was_full || pop_m)) mq.push_back(v);
      if (en && was_full && !pop_m) movf = 1'b1;
    end
    @(negedge clk);
    cap.push_back(tx);
  endtask

  // Independent UART receiver: find each start bit and sample data bits mid-bit.
  task automatic decode();
    int i;
    dec_bytes.delete();
    dec_starts.delete();
    i = 0;
    while (i + FRAME <= cap.size()) begin
      if (cap[i] == 1'b0) begin
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = cap[i + C * (k + 1) + C / 2];
        dec_bytes.push_back(b);
        dec_starts.push_back(i);
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h7777, 1'b1);
      vectors++;
      if (act_vec() !== 4'b1000) begin
        errors++;
        $display("FAIL reset cyc %0d: got %b want 1000", k, act_vec());
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_word();
    int busy_cnt = 0;
    cap.delete();
    step(1'b1, 16'h41A5, 1'b0);
    if (busy) busy_cnt++;
    for (int k = 0; k < 90; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      if (busy) busy_cnt++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_word cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (busy_cnt !== WORD_CYC + 1) begin
      errors++;
      $display("FAIL single_word_busy_len: got %0d want %0d", busy_cnt, WORD_CYC + 1);
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 2 || dec_bytes[0] !== 8'h41 || dec_bytes[1] !== 8'hA5
        || dec_starts[1] - dec_starts[0] != FRAME) begin
      errors++;
      $display("FAIL single_word_frames: got %0d frames first %h", dec_bytes.size(),
               (dec_bytes.size() > 0) ? dec_bytes[0] : 8'hxx);
    end
  endtask

  task automatic test_negative();
    int zeros = 0;
    cap.delete();
    step(1'b1, 16'hFFFE, 1'b0);
    for (int k = 0; k < 90; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL negative cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    foreach (cap[i]) if (cap[i] == 1'b0) zeros++;
    vectors++;
    if (zeros != 3 * C) begin
      errors++;
      $display("FAIL negative_low_cycles: got %0d want %0d", zeros, 3 * C);
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 2 || dec_bytes[0] !== 8'hFF || dec_bytes[1] !== 8'hFE) begin
      errors++;
      $display("FAIL negative_frames: got %0d frames", dec_bytes.size());
    end
  endtask

  task automatic test_overflow();
    step(1'b0, 16'h0000, 1'b1);
    cap.delete();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 16'(k + 1), 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_push %0d: got %b want %b", k + 1, act_vec(), exp_vec());
      end
      if (k == 4) begin
        vectors++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL overflow_full_after_5: got %b want 1", full);
        end
      end
    end
    vectors++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got %b want 1", ovf);
    end
    for (int k = 0; k < 5 * (WORD_CYC + 1) + 10; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_drain cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 10) begin
      errors++;
      $display("FAIL overflow_frame_count: got %0d want 10", dec_bytes.size());
    end else begin
      for (int w = 0; w < 5; w++) begin
        vectors++;
        if ({dec_bytes[2*w], dec_bytes[2*w+1]} !== 16'(w + 1)) begin
          errors++;
          $display("FAIL overflow_word %0d: got %h want %h", w,
                   {dec_bytes[2*w], dec_bytes[2*w+1]}, 16'(w + 1));
        end
      end
    end
  endtask

  task automatic test_full_pop();
    int guard = 0;
    step(1'b0, 16'h0000, 1'b1);
    cap.delete();
    for (int k = 0; k < 5; k++) step(1'b1, 16'(k + 1), 1'b0);
    while (!(rem == 0 && mq.size() > 0) && guard < 200) begin
      step(1'b0, 16'h0000, 1'b0);
      guard++;
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_pop_wait cyc %0d: got %b want %b", guard, act_vec(), exp_vec());
      end
    end
    vectors++;
    if (guard >= 200) begin
      errors++;
      $display("FAIL full_pop_timeout: got %0d cycles want <200", guard);
    end
    step(1'b1, 16'hBEEF, 1'b0);
    vectors++;
    if ({full, ovf} !== 2'b10) begin
      errors++;
      $display("FAIL full_pop_accept: got full=%b ovf=%b want full=1 ovf=0", full, ovf);
    end
    for (int k = 0; k < 5 * (WORD_CYC + 1) + 10; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL full_pop_drain cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 12 || {dec_bytes[10], dec_bytes[11]} !== 16'hBEEF) begin
      errors++;
      $display("FAIL full_pop_last_word: got %0d frames want 12 ending BEEF", dec_bytes.size());
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h55AA, 1'b0);
    while (!(rem > 0 && pos == 4 * C + 1) && guard < 50) begin
      step(1'b0, 16'h0000, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 50 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_reach_bit3: got busy=%b after %0d cycles want 1", busy, guard);
    end
    step(1'b0, 16'h0000, 1'b1);
    vectors++;
    if ({tx, busy, ovf} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_abort: got tx=%b busy=%b ovf=%b want 1 0 0", tx, busy, ovf);
    end
    step(1'b0, 16'h0000, 1'b0);
    cap.delete();
    step(1'b1, 16'h0102, 1'b0);
    for (int k = 0; k < 90; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid_resend cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 2 || dec_bytes[0] !== 8'h01 || dec_bytes[1] !== 8'h02) begin
      errors++;
      $display("FAIL reset_mid_frames: got %0d frames want 01 02", dec_bytes.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want[0] = 8'h12; want[1] = 8'h34; want[2] = 8'h56; want[3] = 8'h78;
    step(1'b0, 16'h0000, 1'b1);
    cap.delete();
    step(1'b1, 16'h1234, 1'b0);
    step(1'b1, 16'h5678, 1'b0);
    for (int k = 0; k < 2 * (WORD_CYC + 1) + 10; k++) begin
      step(1'b0, 16'h0000, 1'b0);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
    decode();
    vectors++;
    if (dec_bytes.size() != 4) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d want 4", dec_bytes.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (dec_bytes[i] !== want[i]) begin
          errors++;
          $display("FAIL back_to_back_byte %0d: got %h want %h", i, dec_bytes[i], want[i]);
        end
      end
      vectors++;
      if (dec_starts[2] - dec_starts[1] != FRAME + 1 || dec_starts[1] - dec_starts[0] != FRAME
          || dec_starts[3] - dec_starts[2] != FRAME) begin
        errors++;
        $display("FAIL back_to_back_gap: got %0d/%0d/%0d want %0d/%0d/%0d",
                 dec_starts[1] - dec_starts[0], dec_starts[2] - dec_starts[1],
                 dec_starts[3] - dec_starts[2], FRAME, FRAME + 1, FRAME);
      end
    end
  endtask

  task automatic test_random();
    logic        en, r;
    logic [15:0] v;
    step(1'b0, 16'h0000, 1'b1);
    for (int k = 0; k < 4000; k++) begin
      en = ($urandom_range(99) < ((k < 2000) ? 3 : 40));
      v  = 16'($urandom);
      r  = ($urandom_range(599) == 0);
      step(en, v, r);
      vectors++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %b want %b", k, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.oen_i  = 1'b0;
    bus.oval_i = '0;
    rst        = 1'b1;
    test_reset();
    test_single_word();
    test_negative();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
